// File: rtl/norm_pkg.sv
// Shared types and helpers for the iterative left-normalizer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: norm_state_t FSM encoding, NORM_W default width, shamt_w() width helper.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } norm_state_t;

  localparam int NORM_W = 8;

  // Width of a shift amount able to express 0..width-1.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/norm_step.sv
// One combinational normalization step: shift left and advance the count.
// Latency: combinational.
// Backpressure: none; the parent decides when to register the result.
// Ports: data/count in; data_nxt/count_nxt out; msb_hit = data_nxt MSB is 1.
// Optional build macro NORM_STEP2_EN: shift by 2 when the top two bits are zero.
module norm_step
  import norm_pkg::*;
#(
  parameter  int WIDTH   = NORM_W,
  localparam int SHAMT_W = shamt_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   data,
  input  logic [SHAMT_W-1:0] count,
  output logic [WIDTH-1:0]   data_nxt,
  output logic [SHAMT_W-1:0] count_nxt,
  output logic               msb_hit
);

`ifdef NORM_STEP2_EN
  // A double step can never overshoot: two zero MSBs means at least two
  // leading zeros remain, so the count stays within WIDTH-1.
  always_comb begin
    if (data[WIDTH-1:WIDTH-2] == 2'b00) begin
      data_nxt  = data << 2;
      count_nxt = count + SHAMT_W'(2);
      msb_hit   = data[WIDTH-3];
    end else begin
      data_nxt  = data << 1;
      count_nxt = count + SHAMT_W'(1);
      msb_hit   = data[WIDTH-2];
    end
  end
`else
  always_comb begin
    data_nxt  = data << 1;
    count_nxt = count + SHAMT_W'(1);
    msb_hit   = data[WIDTH-2];
  end
`endif

endmodule

// File: rtl/seq_normalizer.sv
// Iterative left-normalizer: shifts a word left until its MSB is 1, reports the shift count.
// Latency: lz+1 edges from accept to out_valid (1 + ceil(lz/2) with NORM_STEP2_EN).
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in/in_valid/in_ready; out/shamt/zero/out_valid/out_ready.
// Optional build macro NORM_STEP2_EN (handled inside norm_step).
module seq_normalizer
  import norm_pkg::*;
#(
  parameter  int WIDTH   = NORM_W,
  localparam int SHAMT_W = shamt_w(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out,
  output logic [SHAMT_W-1:0] shamt,
  output logic               zero
);

  norm_state_t        state, state_nxt;
  logic [WIDTH-1:0]   data, step_data;
  logic [SHAMT_W-1:0] count, step_count;
  logic               zero_q;
  logic               msb_hit;
  logic               load, advance;

  norm_step #(.WIDTH(WIDTH)) u_step (
    .data      (data),
    .count     (count),
    .data_nxt  (step_data),
    .count_nxt (step_count),
    .msb_hit   (msb_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load = 1'b1;
          // Zero words and already-normalized words skip SHIFT entirely.
          if (in == '0 || in[WIDTH-1]) state_nxt = DONE;
          else                         state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        advance = 1'b1;
        if (msb_hit) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers double as the output holding registers: they only
  // change on a load or a shift step, so they stay put through DONE and IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      data   <= '0;
      count  <= '0;
      zero_q <= 1'b0;
    end else if (load) begin
      data   <= in;
      count  <= '0;
      zero_q <= (in == '0);
    end else if (advance) begin
      data   <= step_data;
      count  <= step_count;
    end
  end

  assign out   = data;
  assign shamt = count;
  assign zero  = zero_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Self-checking bench for seq_normalizer: directed cases plus randomized words
// compared against a leading-zero reference model.
module tb_seq_normalizer;
  import norm_pkg::*;

  localparam int W  = NORM_W;
  localparam int SW = shamt_w(W);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_w;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_w;
  logic [SW-1:0] shamt;
  logic          zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_normalizer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_w),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_w),
    .shamt     (shamt),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: count leading zeros directly from the word value.
  function automatic int lead_zeros(input logic [W-1:0] v);
    if (v == '0) return 0;
    for (int i = W - 1; i >= 0; i--)
      if (v[i]) return W - 1 - i;
    return 0;
  endfunction

  function automatic int exp_latency(input logic [W-1:0] v);
    int lz;
    lz = lead_zeros(v);
`ifdef NORM_STEP2_EN
    return 1 + (lz + 1) / 2;
`else
    return 1 + lz;
`endif
  endfunction

  // Runs one word through: accept, wait for result, hold for 'hold' cycles
  // with out_ready low, then release while also offering a junk word.
  task automatic run_word(input logic [W-1:0] v, input int hold, input bit busy_junk);
    int            waited;
    int            lat;
    bit            ready_leak;
    logic [W-1:0]  eo;
    logic [SW-1:0] es;
    logic          ez;

    eo = v << lead_zeros(v);
    es = SW'(lead_zeros(v));
    ez = (v == '0);

    waited = 0;
    while (!in_ready && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    check("accept_ready", 32'(in_ready), 32'd1);

    in_w = v; in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    ready_leak = 1'b0;
    if (busy_junk) begin
      in_valid = 1'b1; in_w = '1;
    end else begin
      in_valid = 1'($urandom_range(0, 1)); in_w = W'($urandom);
    end
    while (!out_valid && lat < W + 4) begin
      if (in_ready) ready_leak = 1'b1;
      @(posedge clk); #1; lat++;
    end
    check("latency", 32'(lat), 32'(exp_latency(v)));
    check("busy_in_ready", 32'({ready_leak, in_ready}), 32'd0);
    check("result", 32'({out_valid, zero, shamt, out_w}), 32'({1'b1, ez, es, eo}));

    repeat (hold) begin
      @(posedge clk); #1;
      check("hold", 32'({out_valid, zero, shamt, out_w}), 32'({1'b1, ez, es, eo}));
    end

    out_ready = 1'b1; in_valid = 1'b1; in_w = W'($urandom_range(1, 255));
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_hs", 32'({out_valid, in_ready}), 32'b01);
    check("release_held", 32'({zero, shamt, out_w}), 32'({ez, es, eo}));
  endtask

  initial begin
    logic [W-1:0] v;

    rst = 1'b1; in_valid = 1'b0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'({in_ready, out_valid, zero, shamt, out_w}),
          32'({1'b1, 1'b0, 1'b0, SW'(0), W'(0)}));
    rst = 1'b0;

    run_word(8'd128, 0, 1'b0);
    run_word(8'd16,  1, 1'b0);
    run_word(8'd1,   0, 1'b1);
    run_word(8'd0,   2, 1'b0);
    run_word(8'd37,  5, 1'b0);

    // Reset on the third SHIFT edge discards the word.
    in_w = 8'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_reset", 32'({in_ready, out_valid, zero, shamt, out_w}),
          32'({1'b1, 1'b0, 1'b0, SW'(0), W'(0)}));
    run_word(8'd255, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      v = W'($urandom);
      v = v >> $urandom_range(0, W);
      run_word(v, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
